cbfp_block_norm: RTL and testbench



---
 rtl/cbfp_block_norm.sv | 261 ++++++++++++++++++++++++++
 tb/tb_cbfp_block_norm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cbfp_block_norm.sv
// Convergent block-floating-point normaliser for FFT butterfly stages.
// Beats are buffered in a ping-pong bank while the block-wide minimum
// redundant-sign-bit count is tracked. The finished block is then replayed,
// left-shifted by that exponent and cut to OUT_WIDTH bits. The exponent is
// emitted alongside so that later stages can compensate.
// Optional macro CBFP_ROUND_EN: round half-up with saturation, which adds
// one output pipeline stage. Without it the output is truncated toward -inf.
module cbfp_block_norm #(
    parameter int unsigned IN_WIDTH    = 23,
    parameter int unsigned OUT_WIDTH   = 11,
    parameter int unsigned LANES       = 16,
    parameter int unsigned BLK_BEATS   = 4,
    parameter int unsigned SHIFT_WIDTH = 5,
    parameter int unsigned JOINT_EXP   = 0
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         din_valid,
    input  logic                         din_sop,
    input  logic [LANES*IN_WIDTH-1:0]    din_re,
    input  logic [LANES*IN_WIDTH-1:0]    din_im,
    output logic                         dout_valid,
    output logic                         dout_sop,
    output logic                         dout_eop,
    output logic [LANES*OUT_WIDTH-1:0]   dout_re,
    output logic [LANES*OUT_WIDTH-1:0]   dout_im,
    output logic [SHIFT_WIDTH-1:0]       exp_re,
    output logic [SHIFT_WIDTH-1:0]       exp_im,
    output logic                         err_frame
);

    localparam int unsigned CW      = $clog2(BLK_BEATS);
    localparam int unsigned DROP    = IN_WIDTH - OUT_WIDTH;
    localparam int unsigned EXP_MAX = (1 << SHIFT_WIDTH) - 1;
    localparam logic [CW-1:0] LAST  = CW'(BLK_BEATS - 1);
`ifdef CBFP_ROUND_EN
    // The rounding stage needs the full shifted value.
    localparam int unsigned S1_W = IN_WIDTH;
    localparam logic [IN_WIDTH:0] RND_BIAS = (IN_WIDTH + 1)'(1) << (DROP - 1);
`else
    localparam int unsigned S1_W = OUT_WIDTH;
`endif

    typedef enum logic {StIdle, StPlay} rd_state_e;

    // Redundant sign bits: the leading bits equal to the sign, minus one.
    function automatic logic [SHIFT_WIDTH-1:0] mag(input logic [IN_WIDTH-1:0] x);
        int unsigned n;
        logic        run;
        n   = 0;
        run = 1'b1;
        for (int i = IN_WIDTH - 2; i >= 0; i--) begin
            if (run && (x[i] == x[IN_WIDTH-1])) n++;
            else run = 1'b0;
        end
        mag = (n > EXP_MAX) ? SHIFT_WIDTH'(EXP_MAX) : SHIFT_WIDTH'(n);
    endfunction

    // The shift never overflows because s <= mag of every sample in the block.
    function automatic logic [S1_W-1:0] shift_top(input logic [IN_WIDTH-1:0] v,
                                                  input logic [SHIFT_WIDTH-1:0] s);
        logic [IN_WIDTH-1:0] t;
        t = v << s;
        shift_top = t[IN_WIDTH-1 -: S1_W];
    endfunction

    logic [SHIFT_WIDTH-1:0]     beat_min_re, beat_min_im;
    logic [SHIFT_WIDTH-1:0]     run_min_re, run_min_im;
    logic [SHIFT_WIDTH-1:0]     fold_re, fold_im, joint_min;
    logic [CW-1:0]              cnt, wr_idx;
    logic                       wbank, first_beat, blk_done;
    logic [1:0]                 full;
    logic [SHIFT_WIDTH-1:0]     bexp_re [2];
    logic [SHIFT_WIDTH-1:0]     bexp_im [2];
    logic [LANES*IN_WIDTH-1:0]  mem_re [2][BLK_BEATS];
    logic [LANES*IN_WIDTH-1:0]  mem_im [2][BLK_BEATS];

    rd_state_e                  state;
    logic                       rbank, rd_free;
    logic [CW-1:0]              rd_cnt;
    logic [SHIFT_WIDTH-1:0]     sh_re, sh_im;
    logic [LANES*IN_WIDTH-1:0]  rd_re, rd_im;
    logic [LANES*S1_W-1:0]      s1n_re, s1n_im, s1_re, s1_im;
    logic                       s1_valid, s1_sop, s1_eop;
    logic [SHIFT_WIDTH-1:0]     s1_exp_re, s1_exp_im;

    // Per-beat minimum over all lanes, real and imaginary kept separate.
    always_comb begin
        beat_min_re = SHIFT_WIDTH'(EXP_MAX);
        beat_min_im = SHIFT_WIDTH'(EXP_MAX);
        for (int l = 0; l < LANES; l++) begin
            if (mag(din_re[l*IN_WIDTH +: IN_WIDTH]) < beat_min_re)
                beat_min_re = mag(din_re[l*IN_WIDTH +: IN_WIDTH]);
            if (mag(din_im[l*IN_WIDTH +: IN_WIDTH]) < beat_min_im)
                beat_min_im = mag(din_im[l*IN_WIDTH +: IN_WIDTH]);
        end
    end

    // Write-side decode. A sop restarts the block at beat 0.
    always_comb begin
        first_beat = (cnt == '0) || din_sop;
        wr_idx     = first_beat ? '0 : cnt;
        blk_done   = din_valid && !din_sop && (cnt == LAST);
        fold_re    = (first_beat || beat_min_re < run_min_re) ? beat_min_re : run_min_re;
        fold_im    = (first_beat || beat_min_im < run_min_im) ? beat_min_im : run_min_im;
        joint_min  = (fold_re < fold_im) ? fold_re : fold_im;
    end

    // Write counter, running minima, bank ownership and the sticky frame error.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt        <= '0;
            wbank      <= 1'b0;
            run_min_re <= '1;
            run_min_im <= '1;
            full       <= '0;
            err_frame  <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                bexp_re[b] <= '0;
                bexp_im[b] <= '0;
            end
        end else begin
            if (rd_free) full[rbank] <= 1'b0;
            if (din_valid) begin
                if (din_sop && (cnt != '0)) err_frame <= 1'b1;
                if (blk_done) begin
                    full[wbank]    <= 1'b1;
                    wbank          <= !wbank;
                    cnt            <= '0;
                    run_min_re     <= '1;
                    run_min_im     <= '1;
                    bexp_re[wbank] <= (JOINT_EXP != 0) ? joint_min : fold_re;
                    bexp_im[wbank] <= (JOINT_EXP != 0) ? joint_min : fold_im;
                end else begin
                    run_min_re <= fold_re;
                    run_min_im <= fold_im;
                    cnt        <= wr_idx + 1'b1;
                end
            end
        end
    end

    // Beat storage. The banks need no reset because the full flags gate replay.
    always_ff @(posedge clk) begin
        if (din_valid) begin
            mem_re[wbank][wr_idx] <= din_re;
            mem_im[wbank][wr_idx] <= din_im;
        end
    end

    assign rd_free = (state == StPlay) && (rd_cnt == LAST);
    assign sh_re   = bexp_re[rbank];
    assign sh_im   = bexp_im[rbank];
    assign rd_re   = mem_re[rbank][rd_cnt];
    assign rd_im   = mem_im[rbank][rd_cnt];

    // Shift each lane of the beat being replayed.
    always_comb begin
        s1n_re = '0;
        s1n_im = '0;
        for (int l = 0; l < LANES; l++) begin
            s1n_re[l*S1_W +: S1_W] = shift_top(rd_re[l*IN_WIDTH +: IN_WIDTH], sh_re);
            s1n_im[l*S1_W +: S1_W] = shift_top(rd_im[l*IN_WIDTH +: IN_WIDTH], sh_im);
        end
    end

    // Replay FSM: one beat per cycle. It chains directly into the other bank if that bank is full.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= StIdle;
            rbank     <= 1'b0;
            rd_cnt    <= '0;
            s1_valid  <= 1'b0;
            s1_sop    <= 1'b0;
            s1_eop    <= 1'b0;
            s1_re     <= '0;
            s1_im     <= '0;
            s1_exp_re <= '0;
            s1_exp_im <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    s1_valid <= 1'b0;
                    s1_sop   <= 1'b0;
                    s1_eop   <= 1'b0;
                    if (full[rbank]) begin
                        state  <= StPlay;
                        rd_cnt <= '0;
                    end
                end
                StPlay: begin
                    s1_valid <= 1'b1;
                    s1_sop   <= (rd_cnt == '0);
                    s1_eop   <= (rd_cnt == LAST);
                    s1_re    <= s1n_re;
                    s1_im    <= s1n_im;
                    if (rd_cnt == '0) begin
                        s1_exp_re <= sh_re;
                        s1_exp_im <= sh_im;
                    end
                    if (rd_cnt == LAST) begin
                        rbank  <= !rbank;
                        rd_cnt <= '0;
                        if (!full[!rbank]) state <= StIdle;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef CBFP_ROUND_EN
    // Round half-up, then clamp to the OUT_WIDTH signed range.
    function automatic logic [OUT_WIDTH-1:0] rnd_sat(input logic [IN_WIDTH-1:0] v);
        logic [IN_WIDTH:0] sum;
        sum = {v[IN_WIDTH-1], v} + RND_BIAS;
        if (sum[IN_WIDTH] != sum[IN_WIDTH-1])
            rnd_sat = sum[IN_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                    : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else
            rnd_sat = sum[IN_WIDTH-1:DROP];
    endfunction

    // Extra registered stage that carries the rounded output and its framing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_valid <= 1'b0;
            dout_sop   <= 1'b0;
            dout_eop   <= 1'b0;
            dout_re    <= '0;
            dout_im    <= '0;
            exp_re     <= '0;
            exp_im     <= '0;
        end else begin
            dout_valid <= s1_valid;
            dout_sop   <= s1_sop;
            dout_eop   <= s1_eop;
            exp_re     <= s1_exp_re;
            exp_im     <= s1_exp_im;
            for (int l = 0; l < LANES; l++) begin
                dout_re[l*OUT_WIDTH +: OUT_WIDTH] <= rnd_sat(s1_re[l*S1_W +: S1_W]);
                dout_im[l*OUT_WIDTH +: OUT_WIDTH] <= rnd_sat(s1_im[l*S1_W +: S1_W]);
            end
        end
    end
`else
    // Truncation: stage 1 already holds the top OUT_WIDTH bits.
    always_comb begin
        dout_valid = s1_valid;
        dout_sop   = s1_sop;
        dout_eop   = s1_eop;
        dout_re    = s1_re;
        dout_im    = s1_im;
        exp_re     = s1_exp_re;
        exp_im     = s1_exp_im;
    end
`endif

endmodule

// File: tb/tb_cbfp_block_norm.sv
// Directed bench for cbfp_block_norm. The expected output beats are queued
// when a block is sent, and a monitor pops and compares each valid output beat.
module tb_cbfp_block_norm;

    localparam int unsigned IW = 23;
    localparam int unsigned OW = 11;
    localparam int unsigned LN = 16;
    localparam int unsigned BB = 4;
    localparam int unsigned SW = 5;
`ifdef CBFP_ROUND_EN
    localparam int LAT   = 3;
    localparam int R2048 = 1;
`else
    localparam int LAT   = 2;
    localparam int R2048 = 0;
`endif

    typedef logic [LN*IW-1:0] ivec_t;
    typedef logic [LN*OW-1:0] ovec_t;

    typedef struct {
        logic          sop;
        logic          eop;
        ovec_t         re;
        ovec_t         im;
        logic [SW-1:0] er;
        logic [SW-1:0] ei;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          din_valid, din_sop;
    ivec_t         din_re, din_im;
    logic          dout_valid, dout_sop, dout_eop;
    ovec_t         dout_re, dout_im;
    logic [SW-1:0] exp_re, exp_im;
    logic          err_frame;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   last_t = 0;
    exp_t sb[$];

    cbfp_block_norm #(
        .IN_WIDTH   (IW),
        .OUT_WIDTH  (OW),
        .LANES      (LN),
        .BLK_BEATS  (BB),
        .SHIFT_WIDTH(SW),
        .JOINT_EXP  (0)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din_valid (din_valid),
        .din_sop   (din_sop),
        .din_re    (din_re),
        .din_im    (din_im),
        .dout_valid(dout_valid),
        .dout_sop  (dout_sop),
        .dout_eop  (dout_eop),
        .dout_re   (dout_re),
        .dout_im   (dout_im),
        .exp_re    (exp_re),
        .exp_im    (exp_im),
        .err_frame (err_frame)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ivec_t in_vec(input int fill, input int lane, input int lv);
        ivec_t v;
        for (int l = 0; l < LN; l++) v[l*IW +: IW] = (l == lane) ? IW'(lv) : IW'(fill);
        return v;
    endfunction

    function automatic ovec_t out_vec(input int fill, input int lane, input int lv);
        ovec_t v;
        for (int l = 0; l < LN; l++) v[l*OW +: OW] = (l == lane) ? OW'(lv) : OW'(fill);
        return v;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic send_beat(input logic sop, input ivec_t re, input ivec_t im);
        din_valid = 1'b1;
        din_sop   = sop;
        din_re    = re;
        din_im    = im;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din_sop   = 1'b0;
        last_t    = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue one block of expected output. Beat sk takes sre as its real data.
    task automatic push_block(input int t, input int er, input int ei, input ovec_t ore,
                              input ovec_t oim, input int sk, input ovec_t sre);
        exp_t e;
        for (int k = 0; k < int'(BB); k++) begin
            e.sop = (k == 0);
            e.eop = (k == int'(BB) - 1);
            e.re  = (k == sk) ? sre : ore;
            e.im  = oim;
            e.er  = SW'(er);
            e.ei  = SW'(ei);
            e.cyc = t + LAT + k;
            sb.push_back(e);
        end
    endtask

    task automatic send_const_block(input ivec_t re, input ivec_t im);
        for (int b = 0; b < int'(BB); b++) send_beat(b == 0, re, im);
    endtask

    initial begin
        rstn      = 1'b0;
        din_valid = 1'b0;
        din_sop   = 1'b0;
        din_re    = '0;
        din_im    = '0;
        #3;
        chk("reset_valid_sop_eop", {dout_valid, dout_sop, dout_eop}, 3'b000);
        chk("reset_data", {dout_re, dout_im}, '0);
        chk("reset_exp_err", {exp_re, exp_im, err_frame}, '0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        idle(1);

        fork
            forever begin
                @(negedge clk);
                if (rstn && dout_valid) begin
                    if (sb.size() == 0) begin
                        chk("spurious_dout_valid", dout_valid, 1'b0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("beat_cycle", cyc, e.cyc);
                        chk("dout_sop", dout_sop, e.sop);
                        chk("dout_eop", dout_eop, e.eop);
                        chk("dout_re", dout_re, e.re);
                        chk("dout_im", dout_im, e.im);
                        chk("exp_re", exp_re, e.er);
                        chk("exp_im", exp_im, e.ei);
                    end
                end
            end
        join_none

        // All ones: mag 21, 1<<21 >>> 12 = 512
        send_const_block(in_vec(1, -1, 0), in_vec(1, -1, 0));
        push_block(last_t, 21, 21, out_vec(512, -1, 0), out_vec(512, -1, 0), -1, '0);
        idle(6);

        // Beat 2 lane 5 re = 2^20 sets exp_re=1
        for (int b = 0; b < 4; b++)
            send_beat(b == 0, (b == 2) ? in_vec(1, 5, 1 << 20) : in_vec(1, -1, 0),
                      in_vec(1, -1, 0));
        push_block(last_t, 1, 21, out_vec(0, -1, 0), out_vec(512, -1, 0), 2,
                   out_vec(0, 5, 512));
        idle(6);

        // Full-scale negative lane: exp_re=0, exp_im=22 for all-zero imag
        send_const_block(in_vec(0, 3, -4194304), in_vec(0, -1, 0));
        push_block(last_t, 0, 22, out_vec(0, 3, -1024), out_vec(0, -1, 0), -1, '0);
        idle(6);

        // Two blocks back-to-back
        send_const_block(in_vec(1, -1, 0), in_vec(2, -1, 0));
        push_block(last_t, 21, 20, out_vec(512, -1, 0), out_vec(512, -1, 0), -1, '0);
        send_const_block(in_vec(3, -1, 0), in_vec(-1, -1, 0));
        push_block(last_t, 20, 22, out_vec(768, -1, 0), out_vec(-1024, -1, 0), -1, '0);
        idle(8);

        // 3-cycle gap mid-block
        send_beat(1'b1, in_vec(1, -1, 0), in_vec(1, -1, 0));
        send_beat(1'b0, in_vec(1, -1, 0), in_vec(1, -1, 0));
        idle(3);
        send_beat(1'b0, in_vec(1, -1, 0), in_vec(1, -1, 0));
        send_beat(1'b0, in_vec(1, -1, 0), in_vec(1, -1, 0));
        push_block(last_t, 21, 21, out_vec(512, -1, 0), out_vec(512, -1, 0), -1, '0);
        idle(8);
        chk("err_frame_clean", err_frame, 1'b0);

        // sop at beat 2 aborts: the full-scale partial beats must not affect the exponent
        send_beat(1'b1, in_vec(-4194304, -1, 0), in_vec(-4194304, -1, 0));
        send_beat(1'b0, in_vec(-4194304, -1, 0), in_vec(-4194304, -1, 0));
        send_const_block(in_vec(1, -1, 0), in_vec(1, -1, 0));
        push_block(last_t, 21, 21, out_vec(512, -1, 0), out_vec(512, -1, 0), -1, '0);
        idle(8);
        chk("err_frame_set", err_frame, 1'b1);

        // Near full-scale positive lane forces exp 0; 2048 rounds to 1 or truncates to 0
        send_const_block(in_vec(2048, 0, 4194303), in_vec(0, -1, 0));
        push_block(last_t, 0, 22, out_vec(R2048, 0, 1023), out_vec(0, -1, 0), -1, '0);

        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);

        // Reset while a block is being replayed
        send_const_block(in_vec(1, -1, 0), in_vec(1, -1, 0));
        repeat (LAT) @(posedge clk);
        #2;
        chk("pre_reset_valid", dout_valid, 1'b1);
        rstn = 1'b0;
        #1;
        chk("async_reset_valid", dout_valid, 1'b0);
        chk("async_reset_exp_err", {exp_re, exp_im, err_frame}, '0);
        @(negedge clk);
        rstn = 1'b1;
        idle(10);

        // Recovery after reset
        send_const_block(in_vec(3, -1, 0), in_vec(1, -1, 0));
        push_block(last_t, 20, 21, out_vec(768, -1, 0), out_vec(512, -1, 0), -1, '0);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        idle(4);
        chk("final_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
